// File: rtl/mont_pkg.sv
// Shared types for the Montgomery datapath: limb type and the
// final-subtract stage state encoding.
package mont_pkg;

   localparam int MONT_WIDTH = 32;
   localparam int MONT_S     = 8;

   typedef logic [MONT_WIDTH-1:0] limb_t;

   typedef enum logic [1:0] {
      IDLE,
      SUB,
      TOP,
      DONE
   } mfs_state_e;

endpackage

// File: rtl/limb_sub.sv
// One-limb subtractor a - b - bin, borrow taken from the
// WIDTH+1-bit result.
module limb_sub #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic [WIDTH-1:0] diff,
   output logic             bout
);

   logic [WIDTH:0] w_res;

   assign w_res = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, bin};
   assign diff  = w_res[WIDTH-1:0];
   assign bout  = w_res[WIDTH];

endmodule

// File: rtl/mont_final_sub.sv
// Limb-serial final conditional subtract of CIOS Montgomery: r = T>=p ? T-p : T.
// Optional MONT_FINAL_SUB_FLAG_EN adds the sub_taken debug output.
module mont_final_sub
   import mont_pkg::*;
#(
   parameter int WIDTH = MONT_WIDTH,
   parameter int S     = MONT_S
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [(S+1)*WIDTH-1:0] t_in,
   input  logic [S*WIDTH-1:0]     p,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [S*WIDTH-1:0]     r_out,
`ifdef MONT_FINAL_SUB_FLAG_EN
   output logic                   sub_taken,
`endif
   output logic                   busy
);

   localparam int IW = (S > 1) ? $clog2(S) : 1;

   mfs_state_e                r_state;
   logic [S:0][WIDTH-1:0]     r_t;
   logic [S-1:0][WIDTH-1:0]   r_p;
   logic [S-1:0][WIDTH-1:0]   r_d;
   logic [IW-1:0]             r_idx;
   logic                      r_borrow;

   logic [S-1:0][WIDTH-1:0]   w_tlo;
   logic [WIDTH-1:0]          w_a;
   logic [WIDTH-1:0]          w_b;
   logic [WIDTH-1:0]          w_diff;
   logic                      w_bout;
   logic                      w_fb;

   assign w_tlo = r_t[S-1:0];
   assign w_a   = w_tlo[r_idx];
   assign w_b   = r_p[r_idx];

   // Top limb absorbs the last borrow; leftover borrow means T < p.
   assign w_fb  = (r_t[S] == '0) & r_borrow;

   assign in_ready = (r_state == IDLE);
   assign busy     = (r_state != IDLE);

   limb_sub #(
      .WIDTH(WIDTH)
   ) u_limb_sub (
      .a    (w_a),
      .b    (w_b),
      .bin  (r_borrow),
      .diff (w_diff),
      .bout (w_bout)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= IDLE;
         r_t       <= '0;
         r_p       <= '0;
         r_d       <= '0;
         r_idx     <= '0;
         r_borrow  <= 1'b0;
         r_out     <= '0;
         out_valid <= 1'b0;
`ifdef MONT_FINAL_SUB_FLAG_EN
         sub_taken <= 1'b0;
`endif
      end else begin
         unique case (r_state)
            IDLE: begin
               if (in_valid) begin
                  r_t      <= t_in;
                  r_p      <= p;
                  r_idx    <= '0;
                  r_borrow <= 1'b0;
                  r_state  <= SUB;
               end
            end
            SUB: begin
               r_d[r_idx] <= w_diff;
               r_borrow   <= w_bout;
               r_idx      <= r_idx + IW'(1);
               if (r_idx == IW'(S-1))
                  r_state <= TOP;
            end
            TOP: begin
               r_out     <= w_fb ? w_tlo : r_d;
               out_valid <= 1'b1;
               r_idx     <= '0;
`ifdef MONT_FINAL_SUB_FLAG_EN
               sub_taken <= !w_fb;
`endif
               r_state   <= DONE;
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  r_state   <= IDLE;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mont_final_sub.sv
// Directed bench for mont_final_sub at WIDTH=8, S=2, p=0xC105.
// Checks sub_taken too when MONT_FINAL_SUB_FLAG_EN is defined.
module tb_mont_final_sub;

   localparam int WIDTH = 8;
   localparam int S     = 2;
   localparam logic [15:0] P = 16'hC105;

   logic                   clk = 1'b0;
   logic                   rst;
   logic                   in_valid;
   logic                   in_ready;
   logic [(S+1)*WIDTH-1:0] t_in;
   logic [S*WIDTH-1:0]     p;
   logic                   out_valid;
   logic                   out_ready;
   logic [S*WIDTH-1:0]     r_out;
   logic                   busy;
`ifdef MONT_FINAL_SUB_FLAG_EN
   logic                   sub_taken;
`endif

   int nchk = 0;
   int nerr = 0;

   mont_final_sub #(
      .WIDTH(WIDTH),
      .S    (S)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .t_in      (t_in),
      .p         (p),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .r_out     (r_out),
`ifdef MONT_FINAL_SUB_FLAG_EN
      .sub_taken (sub_taken),
`endif
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      nchk++;
      assert (obs === exp)
      else begin
         nerr++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present T, take the accept edge, then scramble inputs.
   task automatic accept(input string tag, input logic [23:0] t);
      p        = P;
      t_in     = t;
      in_valid = 1'b1;
      chk({tag, ":in_ready"}, 32'(in_ready), 32'd1);
      step();
      in_valid = 1'b0;
      t_in     = 24'hA5A5A5;
      p        = 16'hFFFF;
      chk({tag, ":busy"}, 32'(busy), 32'd1);
      chk({tag, ":in_ready_lo"}, 32'(in_ready), 32'd0);
   endtask

   // Two SUB cycles then TOP: out_valid rises after edge k+3.
   task automatic result(input string tag, input logic [15:0] r,
                         input logic taken);
      step();
      chk({tag, ":ov_k1"}, 32'(out_valid), 32'd0);
      step();
      chk({tag, ":ov_k2"}, 32'(out_valid), 32'd0);
      step();
      chk({tag, ":ov_k3"}, 32'(out_valid), 32'd1);
      chk({tag, ":r_out"}, 32'(r_out), 32'(r));
`ifdef MONT_FINAL_SUB_FLAG_EN
      chk({tag, ":sub_taken"}, 32'(sub_taken), 32'(taken));
`else
      if (taken === 1'bx) $display("unreachable");
`endif
   endtask

   task automatic release_out(input string tag);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk({tag, ":ov_clr"}, 32'(out_valid), 32'd0);
      chk({tag, ":idle"}, 32'(in_ready), 32'd1);
      chk({tag, ":busy_clr"}, 32'(busy), 32'd0);
   endtask

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      t_in      = '0;
      p         = P;
      step();
      step();
      chk("rst:in_ready", 32'(in_ready), 32'd1);
      chk("rst:out_valid", 32'(out_valid), 32'd0);
      chk("rst:busy", 32'(busy), 32'd0);
      chk("rst:r_out", 32'(r_out), 32'd0);
`ifdef MONT_FINAL_SUB_FLAG_EN
      chk("rst:sub_taken", 32'(sub_taken), 32'd0);
`endif
      rst = 1'b0;
      step();

      accept("lt", 24'h001234);
      result("lt", 16'h1234, 1'b0);
      release_out("lt");

      accept("eq", 24'h00C105);
      result("eq", 16'h0000, 1'b1);
      release_out("eq");

      accept("top", 24'h010203);
      result("top", 16'h40FE, 1'b1);
      release_out("top");

      accept("pm1", 24'h00C104);
      result("pm1", 16'hC104, 1'b0);
      release_out("pm1");

      // Back-pressure: hold DONE while a new T waits on in_valid.
      accept("bp0", 24'h00C105);
      result("bp0", 16'h0000, 1'b1);
      p        = P;
      t_in     = 24'h000007;
      in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         chk("bp:out_valid", 32'(out_valid), 32'd1);
         chk("bp:r_out", 32'(r_out), 32'h0000);
         chk("bp:in_ready", 32'(in_ready), 32'd0);
      end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk("bp:ov_clr", 32'(out_valid), 32'd0);
      chk("bp:idle", 32'(in_ready), 32'd1);
      accept("bp1", 24'h000007);
      result("bp1", 16'h0007, 1'b0);
      release_out("bp1");

      // Reset during the second SUB cycle.
      accept("rs", 24'h010203);
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("rs:out_valid", 32'(out_valid), 32'd0);
      chk("rs:in_ready", 32'(in_ready), 32'd1);
      chk("rs:busy", 32'(busy), 32'd0);
      chk("rs:r_out", 32'(r_out), 32'd0);
      accept("rs2", 24'h00C105);
      result("rs2", 16'h0000, 1'b1);
      release_out("rs2");

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/mont_final_sub.md
Name: mont_final_sub

Overview:
- Downstream stage of the CIOS Montgomery multiplier in the Paillier datapath.
- Consumes the (S+1)-limb intermediate T, which is < 2p, and the modulus p. Produces the fully reduced S-limb result r = (T >= p) ? T - p : T.
- Limb-serial: one WIDTH-bit subtract per cycle. Uses a valid/ready handshake on both sides so it can decouple the multiplier from the next consumer.

Parameters:
- WIDTH, 32, limb width in bits.
- S, 8, number of modulus limbs. T carries S+1 limbs.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  T and p are presented.
- in_ready  output  1  block can accept an operand.
- t_in  input  (S+1) x WIDTH  multiplier output T; limb 0 is least significant.
- p  input  S x WIDTH  modulus; limb 0 is least significant.
- out_valid  output  1  r_out holds a result.
- out_ready  input  1  consumer accepts the result.
- r_out  output  S x WIDTH  reduced result; limb 0 is least significant.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset: state=IDLE, in_ready=1, out_valid=0, busy=0, r_out=0, limb index=0, borrow=0, T/p/D buffers cleared. A reset in any state, including mid-SUB or DONE, aborts the operation and discards the result. The block returns to IDLE on the next cycle.
- State machine:
  - IDLE: in_ready=1. When in_valid&&in_ready, capture t_in and p into internal registers, set idx=0 and borrow=0, then go to SUB.
  - SUB, S cycles: D[idx] = T[idx] - p[idx] - borrow, modulo 2^WIDTH. The new borrow is 1 when T[idx] < p[idx] + borrow, evaluated at WIDTH+1 bits. idx increments each cycle. Go to TOP after idx=S-1.
  - TOP, 1 cycle: final borrow fb = (T[S] < borrow). If fb=1 then T < p and r_out <= T[S-1:0]; otherwise r_out <= D. Set out_valid=1 and go to DONE.
  - DONE: hold r_out and out_valid stable. When out_ready=1, clear out_valid and return to IDLE. in_ready is 0 while in DONE, so there is no same-cycle re-accept.
- Latency: accept edge k gives out_valid high after edge k+S+1. Minimum initiation interval is S+3 cycles.
- in_ready=0 in SUB, TOP and DONE. in_valid may stay high during these states and is ignored; t_in is sampled only on the accepting edge.
- Changing t_in or p after acceptance has no effect on the operation in progress.
- T = p gives r = 0. T = p-1 gives r = p-1, with the borrow propagating through all limbs.
- T >= 2p violates the upstream contract. The output is T-p, which is still >= p. No error is flagged.
- The data path has the same timing regardless of the data: cycle count does not depend on T or p.

Optional Feature:
- Macro: MONT_FINAL_SUB_FLAG_EN.
- Defined: adds output port sub_taken (1 bit). It is loaded in TOP with !fb, is valid whenever out_valid=1, is held through DONE, and resets to 0. For debug/coverage only.
- Undefined: the port and its register are absent. All other behaviour is identical.

Decomposition:
- Shared package mont_pkg:
  - limb_t typedef (logic [WIDTH-1:0]), with WIDTH taken from a package localparam that matches the multiplier.
  - mfs_state_e enum: IDLE, SUB, TOP, DONE.
- Sub-module limb_sub: combinational a - b - bin, producing diff[WIDTH-1:0] and bout. Instantiated once and shared across limbs by idx muxing.

Test Plan:
All cases use WIDTH=8, S=2, p = {0xC1, 0x05}.
- T = 0x00_12_34 -> r_out = 0x1234 after 3 cycles (S+1); sub_taken=0.
- T = 0x00_C1_05 (= p) -> r_out = 0x0000; sub_taken=1.
- T = 0x01_02_03 -> r_out = 0x40FE, with borrow out of limb 1 absorbed by the top limb; sub_taken=1.
- T = 0x00_C1_04 (p-1) -> r_out = 0xC104; sub_taken=0.
- Back-pressure:
  - Stimulus: out_ready=0 for 5 cycles in DONE while in_valid is held with T = 0x00_00_07.
  - Required: r_out and out_valid stay stable and in_ready stays 0.
  - Then: raising out_ready completes the handshake, the next cycle accepts the new T, and r_out = 0x0007.
- Reset mid-operation:
  - Stimulus: assert rst in the 2nd SUB cycle of T = 0x01_02_03.
  - Required next cycle: out_valid=0, in_ready=1, busy=0.
  - Then: a fresh T = 0x00_C1_05 yields r_out = 0x0000 with nominal latency.
